// File: rtl/ttl_magnitude_comparator_serial_digit_compare.sv
// Combinational DIGIT-wide magnitude compare used by the serial comparator.
// Ports:
//    a, b  : digit operands
//    lt    : a < b
//    eq    : a == b
//    gt    : a > b
module digit_compare #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   assign lt = (a < b);
   assign eq = (a == b);
   assign gt = (a > b);

endmodule

// File: rtl/ttl_magnitude_comparator_serial.sv
// Clocked, cascadable magnitude comparator for WIDTH_IN-bit words.
// DIGIT bits are compared per clock, most significant digit first, stopping
// at the first digit that differs. Words that are equal all the way down are
// resolved from the captured cascade inputs, using 7485-style parallel
// expansion rules.
//
// Ports:
//    Clk            rising-edge clock
//    Clear          asynchronous active-high reset
//    Start          request; only looked at while Busy=0
//    A, B           operands, captured on the accepting edge
//    ALess_in       cascade input, captured with A/B
//    Equal_in       cascade input, captured with A/B
//    AGreater_in    cascade input, captured with A/B
//    Busy           comparison in progress
//    Done           one-cycle pulse when a new result is loaded
//    ALess_out      registered result
//    Equal_out      registered result
//    AGreater_out   registered result
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for Start (also the Done cycle, so back-to-back works)
// S_COMPARE | comparing digit idx_q of the captured operands
module ttl_magnitude_comparator_serial #(
   parameter int WIDTH_IN   = 16,
   parameter int DIGIT      = 4,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic                Clk,
   input  logic                Clear,
   input  logic                Start,
   input  logic [WIDTH_IN-1:0] A,
   input  logic [WIDTH_IN-1:0] B,
   input  logic                ALess_in,
   input  logic                Equal_in,
   input  logic                AGreater_in,
   output logic                Busy,
   output logic                Done,
   output logic                ALess_out,
   output logic                Equal_out,
   output logic                AGreater_out
);

   localparam int NUM_DIGITS = WIDTH_IN / DIGIT;
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_COMPARE = 1'b1
   } state_t;

   if (WIDTH_IN % DIGIT != 0) begin : g_bad_width
      $error("WIDTH_IN must be a multiple of DIGIT");
   end

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q;
   logic [WIDTH_IN-1:0] a_q, b_q;
   logic                less_in_q, equal_in_q, greater_in_q;
   logic                done_q;
   logic                less_q, equal_q, greater_q;

   logic [DIGIT-1:0]    a_dig, b_dig;
   logic                dig_lt, dig_eq, dig_gt;
   logic                accept, terminate;
   logic                less_d, equal_d, greater_d;

   assign a_dig = a_q[idx_q*DIGIT +: DIGIT];
   assign b_dig = b_q[idx_q*DIGIT +: DIGIT];

   digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
      .a  (a_dig),
      .b  (b_dig),
      .lt (dig_lt),
      .eq (dig_eq),
      .gt (dig_gt)
   );

   // State register plus the datapath registers it sequences.
   always_ff @(posedge Clk or posedge Clear) begin
      if (Clear) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         less_in_q    <= 1'b0;
         equal_in_q   <= 1'b0;
         greater_in_q <= 1'b0;
         done_q       <= 1'b0;
         less_q       <= 1'b0;
         equal_q      <= 1'b0;
         greater_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= terminate;
         if (accept) begin
            a_q          <= A;
            b_q          <= B;
            less_in_q    <= ALess_in;
            equal_in_q   <= Equal_in;
            greater_in_q <= AGreater_in;
            idx_q        <= IDX_W'(NUM_DIGITS - 1);
         end else if (state_q == S_COMPARE && !terminate) begin
            idx_q <= idx_q - 1'b1;
         end
         if (terminate) begin
            less_q    <= less_d;
            equal_q   <= equal_d;
            greater_q <= greater_d;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (accept) state_d = S_COMPARE;
         S_COMPARE: if (terminate) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Result selection: a differing digit decides directly; an all-equal word
   // falls through to the cascade inputs. With Equal_in low and the other two
   // cascade inputs matching, both outputs are inverted (parallel expansion).
   always_comb begin
      accept    = (state_q == S_IDLE) && Start;
      terminate = (state_q == S_COMPARE) && (!dig_eq || idx_q == '0);
      less_d    = dig_lt;
      equal_d   = 1'b0;
      greater_d = dig_gt;
      if (dig_eq) begin
         if (equal_in_q) begin
            less_d    = 1'b0;
            equal_d   = 1'b1;
            greater_d = 1'b0;
         end else if (less_in_q != greater_in_q) begin
            less_d    = less_in_q;
            greater_d = greater_in_q;
         end else begin
            less_d    = !less_in_q;
            greater_d = !greater_in_q;
         end
      end
   end

   assign #(DELAY_RISE, DELAY_FALL) Busy         = (state_q == S_COMPARE);
   assign #(DELAY_RISE, DELAY_FALL) Done         = done_q;
   assign #(DELAY_RISE, DELAY_FALL) ALess_out    = less_q;
   assign #(DELAY_RISE, DELAY_FALL) Equal_out    = equal_q;
   assign #(DELAY_RISE, DELAY_FALL) AGreater_out = greater_q;

endmodule

// File: tb/tb_ttl_magnitude_comparator_serial.sv
module tb_ttl_magnitude_comparator_serial;

   logic        clk = 1'b0;
   logic        clear, start;
   logic [15:0] a, b;
   logic        li, ei, gi;
   logic        busy1, done1, lt1, eq1, gt1;
   logic        busy2, done2, lt2, eq2, gt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ttl_magnitude_comparator_serial #(.WIDTH_IN(16), .DIGIT(4)) dut4 (
      .Clk(clk), .Clear(clear), .Start(start), .A(a), .B(b),
      .ALess_in(li), .Equal_in(ei), .AGreater_in(gi),
      .Busy(busy1), .Done(done1), .ALess_out(lt1), .Equal_out(eq1), .AGreater_out(gt1)
   );

   ttl_magnitude_comparator_serial #(.WIDTH_IN(16), .DIGIT(16)) dut16 (
      .Clk(clk), .Clear(clear), .Start(start), .A(a), .B(b),
      .ALess_in(li), .Equal_in(ei), .AGreater_in(gi),
      .Busy(busy2), .Done(done2), .ALess_out(lt2), .Equal_out(eq2), .AGreater_out(gt2)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: latency is the 1-based MSB position of the first differing digit.
   function automatic int lat_of(input logic [15:0] x, input logic [15:0] y, input int dig);
      int nd = 16 / dig;
      logic [31:0] mask = (32'h1 << dig) - 32'h1;
      for (int i = 0; i < nd; i++) begin
         int sh = (nd - 1 - i) * dig;
         if (((32'(x) >> sh) & mask) != ((32'(y) >> sh) & mask)) return i + 1;
      end
      return nd;
   endfunction

   // Reference result as {less, equal, greater}.
   function automatic logic [2:0] ref_res(input logic [15:0] x, input logic [15:0] y,
                                          input logic l, input logic e, input logic g);
      if (x < y) return 3'b100;
      if (x > y) return 3'b001;
      if (e) return 3'b010;
      if (l != g) return {l, 1'b0, g};
      return {~l, 1'b0, ~g};
   endfunction

   bit         m_busy[2];
   bit         m_done[2];
   int         m_rem[2];
   logic [2:0] m_res[2];
   logic [2:0] m_pend[2];

   // Per-cycle compare and model advance. Inputs change only just after a
   // rising edge, so at the falling edge they are what the next edge samples.
   always @(negedge clk) begin
      logic [4:0] got [2];
      got[0] = {busy1, done1, lt1, eq1, gt1};
      got[1] = {busy2, done2, lt2, eq2, gt2};
      if (clear) begin
         for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_done[d] = 0; m_rem[d] = 0; m_res[d] = 3'b000;
         end
      end
      chk("cycle_dig4",  32'(got[0]), 32'({m_busy[0], m_done[0], m_res[0]}));
      chk("cycle_dig16", 32'(got[1]), 32'({m_busy[1], m_done[1], m_res[1]}));
      if (!clear) begin
         for (int d = 0; d < 2; d++) begin
            m_done[d] = 0;
            if (m_busy[d]) begin
               m_rem[d]--;
               if (m_rem[d] == 0) begin
                  m_busy[d] = 0;
                  m_done[d] = 1;
                  m_res[d]  = m_pend[d];
               end
            end else if (start) begin
               m_busy[d] = 1;
               m_rem[d]  = lat_of(a, b, (d == 0) ? 4 : 16);
               m_pend[d] = ref_res(a, b, li, ei, gi);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy1 || busy2) && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("idle_timeout", 32'(busy1 || busy2), 32'd0);
   endtask

   task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic l, input logic e, input logic g,
                         input int exp_lat, input logic [2:0] exp_out);
      int k = 0;
      bit seen = 0;
      wait_idle();
      chk({name, "_model_lat"}, 32'(lat_of(x, y, 4)), 32'(exp_lat));
      chk({name, "_model_res"}, 32'(ref_res(x, y, l, e, g)), 32'(exp_out));
      a = x; b = y; li = l; ei = e; gi = g; start = 1;
      @(posedge clk); #1;
      start = 0;
      a = ~x; b = x; li = ~l; ei = ~e; gi = ~g;
      while (!seen && k < 20) begin
         @(posedge clk); #1; k++;
         if (k == 1) chk({name, "_dig16_done"}, 32'(done2), 32'd1);
         if (done1) seen = 1;
      end
      chk({name, "_latency"}, seen ? 32'(k) : 32'hFFFF, 32'(exp_lat));
      chk({name, "_result"}, 32'({lt1, eq1, gt1}), 32'(exp_out));
   endtask

   initial begin
      int pulses;
      logic [15:0] tmp;
      clear = 1; start = 0; a = '0; b = '0; li = 0; ei = 0; gi = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({busy1, done1, lt1, eq1, gt1, busy2, done2, lt2, eq2, gt2}), 32'd0);
      clear = 0;
      @(posedge clk); #1;

      run_op("eq_word",   16'h1234, 16'h1234, 0, 1, 0, 4, 3'b010);
      run_op("msb_diff",  16'h8000, 16'h7FFF, 0, 0, 0, 1, 3'b001);
      run_op("third_dig", 16'h12A4, 16'h12B4, 0, 0, 0, 3, 3'b100);
      run_op("casc_00",   16'h00FF, 16'h00FF, 0, 0, 0, 4, 3'b101);
      run_op("casc_11",   16'h00FF, 16'h00FF, 1, 0, 1, 4, 3'b000);
      run_op("casc_10",   16'h00FF, 16'h00FF, 1, 0, 0, 4, 3'b100);

      // Clear in the middle of an equal-word compare.
      wait_idle();
      a = 16'hFFFF; b = 16'hFFFF; ei = 1; start = 1;
      @(posedge clk); #1; start = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clear = 1;
      #1;
      chk("clear_async", 32'({busy1, done1, lt1, eq1, gt1}), 32'd0);
      @(posedge clk); #1;
      clear = 0;
      pulses = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done1) pulses++;
      end
      chk("clear_no_done", 32'(pulses), 32'd0);

      // Start re-pulsed while busy must be ignored.
      wait_idle();
      a = 16'h5A5A; b = 16'h5A5A; li = 0; ei = 1; gi = 0; start = 1;
      @(posedge clk); #1;
      a = 16'h0000; b = 16'hFFFF; ei = 0;
      repeat (3) begin @(posedge clk); #1; end
      start = 0;
      pulses = 0;
      while (!done1 && pulses < 10) begin @(posedge clk); #1; pulses++; end
      chk("busy_ignore_done", 32'(done1), 32'd1);
      chk("busy_ignore_res", 32'({lt1, eq1, gt1}), 32'b010);

      // Back-to-back with Start held: one Done every 5 cycles for equal words.
      wait_idle();
      a = 16'hC3C3; b = 16'hC3C3; ei = 1; start = 1;
      pulses = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done1) pulses++;
      end
      chk("b2b_pulses", 32'(pulses), 32'd4);

      // Randomized phase: held Start first, then random Start.
      for (int cyc = 0; cyc < 600; cyc++) begin
         a = 16'($urandom);
         case ($urandom_range(0, 2))
            0: b = a;
            1: begin
               tmp = 16'($urandom_range(1, 15));
               b = a ^ (tmp << (4 * $urandom_range(0, 3)));
            end
            default: b = 16'($urandom);
         endcase
         li = 1'($urandom); ei = 1'($urandom); gi = 1'($urandom);
         start = (cyc < 300) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      start = 0;
      repeat (8) begin @(posedge clk); #1; end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
